// File: rtl/core_avl_arbiter_2to1.sv
// core_avl_arbiter_2to1
// Two requesters (m0 = instruction fetch, m1 = load/store unit) share one
// Avalon-MM master port. Grants alternate round-robin. A requester can lock
// the grant to keep a split unaligned access atomic. The requester ID of each
// accepted read is queued in order, so every read response goes back to the
// requester that issued it. Commands and responses pass through with no
// added cycles.
module core_avl_arbiter_2to1 #(
   parameter int DEPTH = 4,   // maximum outstanding reads (power of two, >= 2)
   parameter int AW    = 32,  // address width
   parameter int DW    = 32   // data width
) (
   input  logic            clk,
   input  logic            rest,

   // requester 0: instruction fetch
   input  logic [AW-1:0]   m0_address,
   input  logic            m0_read,
   input  logic            m0_write,
   input  logic [DW/8-1:0] m0_byte_en,
   input  logic [DW-1:0]   m0_write_data,
   input  logic            m0_lock,
   output logic            m0_request_ready,
   output logic [DW-1:0]   m0_read_data,
   output logic            m0_read_data_valid,

   // requester 1: load/store unit
   input  logic [AW-1:0]   m1_address,
   input  logic            m1_read,
   input  logic            m1_write,
   input  logic [DW/8-1:0] m1_byte_en,
   input  logic [DW-1:0]   m1_write_data,
   input  logic            m1_lock,
   output logic            m1_request_ready,
   output logic [DW-1:0]   m1_read_data,
   output logic            m1_read_data_valid,

   // shared bus port
   output logic [AW-1:0]   s_address,
   output logic            s_read,
   output logic            s_write,
   output logic [DW/8-1:0] s_byte_en,
   output logic [DW-1:0]   s_write_data,
   input  logic            s_request_ready,
   input  logic [DW-1:0]   s_read_data,
   input  logic            s_read_data_valid,

   // sticky flag: a response arrived while no read was outstanding
   output logic            resp_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // pointer width
   localparam int CW = PW + 1;                           // count width, holds DEPTH

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic          last_grant;   // requester granted by the last accepted command
   logic          locked;       // grant pinned to lock_owner
   logic          lock_owner;
   logic [CW-1:0] count;        // outstanding reads
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [DEPTH-1:0] id_mem;    // requester ID of each outstanding read, in issue order

   // ---------------------------------------------------------------------
   // Combinational signals
   // ---------------------------------------------------------------------
   logic          req0;
   logic          req1;
   logic          grant;        // requester granted this cycle
   logic          sel;          // mux select; forced to m0 while in reset
   logic          full;
   logic          g_read;
   logic          g_write;
   logic          g_lock;
   logic          accept;
   logic          push;
   logic          pop;
   logic          head_id;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;
   assign full = (count == CW'(DEPTH));

   // Round-robin grant, pinned to the lock owner while a lock is held
   always_comb begin
      // NOTE: assigning a default before any branch keeps always_comb free of inferred latches.
      grant = last_grant;
      if (locked) begin
         grant = lock_owner;
      end else if (req0 && !req1) begin
         grant = 1'b0;
      end else if (req1 && !req0) begin
         grant = 1'b1;
      end else if (req0 && req1) begin
         grant = ~last_grant;
      end
   end

   assign sel = rest ? 1'b0 : grant;

   // Route the selected requester's command to the bus
   always_comb begin
      s_address    = m0_address;
      s_byte_en    = m0_byte_en;
      s_write_data = m0_write_data;
      g_read       = m0_read;
      g_write      = m0_write;
      g_lock       = m0_lock;
      if (sel) begin
         s_address    = m1_address;
         s_byte_en    = m1_byte_en;
         s_write_data = m1_write_data;
         g_read       = m1_read;
         g_write      = m1_write;
         g_lock       = m1_lock;
      end
   end

   // Hold back a read while the ID queue is full. Writes are never held back.
   // Both are suppressed while in reset.
   assign s_read  = ~rest & g_read & ~full;
   assign s_write = ~rest & g_write;

   assign accept           = s_request_ready & (s_read | s_write);
   assign m0_request_ready = accept & ~sel;
   assign m1_request_ready = accept & sel;

   // Response routing from the head of the ID queue
   assign push    = accept & s_read;
   assign pop     = s_read_data_valid & (count != '0);
   assign head_id = id_mem[rd_ptr];

   assign m0_read_data_valid = pop & ~head_id;
   assign m1_read_data_valid = pop & head_id;
   assign m0_read_data       = rest ? '0 : s_read_data;
   assign m1_read_data       = rest ? '0 : s_read_data;

   // ---------------------------------------------------------------------
   // Sequential logic
   // ---------------------------------------------------------------------

   // Arbitration history and lock tracking
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         // NOTE: non-blocking assignments for all state, so every register samples pre-edge values.
         last_grant <= 1'b1;
         locked     <= 1'b0;
         lock_owner <= 1'b0;
      end else if (accept) begin
         last_grant <= grant;
         if (g_lock) begin
            locked     <= 1'b1;
            lock_owner <= grant;
         end else if (locked && (lock_owner == grant)) begin
            locked <= 1'b0;
         end
      end
   end

   // ID queue pointers and occupancy
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   // ID queue storage
   // NOTE: storage is left unreset. Cleared pointers and count make its old contents unreachable.
   always_ff @(posedge clk) begin
      if (push) begin
         id_mem[wr_ptr] <= grant;
      end
   end

   // Sticky error when a response has no matching outstanding read
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         resp_err <= 1'b0;
      end else if (s_read_data_valid && (count == '0)) begin
         resp_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_core_avl_arbiter_2to1.sv
// Directed testbench for core_avl_arbiter_2to1.
// Inputs change 1 ns after each rising edge. Outputs are sampled 2 ns later.
module tb_core_avl_arbiter_2to1;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;

   logic            clk;
   logic            rest;
   logic [AW-1:0]   m0_address, m1_address;
   logic            m0_read, m1_read, m0_write, m1_write;
   logic [DW/8-1:0] m0_byte_en, m1_byte_en;
   logic [DW-1:0]   m0_write_data, m1_write_data;
   logic            m0_lock, m1_lock;
   logic            m0_request_ready, m1_request_ready;
   logic [DW-1:0]   m0_read_data, m1_read_data;
   logic            m0_read_data_valid, m1_read_data_valid;
   logic [AW-1:0]   s_address;
   logic            s_read, s_write;
   logic [DW/8-1:0] s_byte_en;
   logic [DW-1:0]   s_write_data;
   logic            s_request_ready;
   logic [DW-1:0]   s_read_data;
   logic            s_read_data_valid;
   logic            resp_err;

   int checks   = 0;
   int failures = 0;

   core_avl_arbiter_2to1 #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rest(rest),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byte_en(m0_byte_en), .m0_write_data(m0_write_data), .m0_lock(m0_lock),
      .m0_request_ready(m0_request_ready), .m0_read_data(m0_read_data),
      .m0_read_data_valid(m0_read_data_valid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byte_en(m1_byte_en), .m1_write_data(m1_write_data), .m1_lock(m1_lock),
      .m1_request_ready(m1_request_ready), .m1_read_data(m1_read_data),
      .m1_read_data_valid(m1_read_data_valid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_byte_en(s_byte_en), .s_write_data(s_write_data),
      .s_request_ready(s_request_ready), .s_read_data(s_read_data),
      .s_read_data_valid(s_read_data_valid), .resp_err(resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      m0_read = 0; m0_write = 0; m0_lock = 0; m0_address = '0;
      m1_read = 0; m1_write = 0; m1_lock = 0; m1_address = '0;
      m0_byte_en = '1; m1_byte_en = '1; m0_write_data = '0; m1_write_data = '0;
      s_request_ready = 1; s_read_data_valid = 0; s_read_data = '0;
   endtask

   // Advance to 1 ns after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- reset state ----------------
      idle();
      rest = 1;
      m0_address = 32'h55; m0_read = 1;
      m1_address = 32'h66; m1_read = 1;
      s_read_data_valid = 1; s_read_data = 32'hDEAD;
      #3;
      check("rst_s_address", s_address, 32'h55);
      check("rst_s_read", s_read, 0);
      check("rst_s_write", s_write, 0);
      check("rst_m0_ready", m0_request_ready, 0);
      check("rst_m1_ready", m1_request_ready, 0);
      check("rst_m0_valid", m0_read_data_valid, 0);
      check("rst_m1_valid", m1_read_data_valid, 0);
      check("rst_m0_rdata", m0_read_data, 0);
      check("rst_resp_err", resp_err, 0);
      tick();
      rest = 0;
      idle();

      // ---------------- round-robin reads, 1-cycle response ----------------
      for (int i = 0; i < 6; i++) begin
         m0_read = 1; m0_address = 32'h100;
         m1_read = 1; m1_address = 32'h200;
         s_read_data_valid = (i > 0);
         s_read_data = 32'hD000 + i;
         #2;
         check($sformatf("rr_addr_%0d", i), s_address, (i % 2 == 0) ? 32'h100 : 32'h200);
         check($sformatf("rr_m0_ready_%0d", i), m0_request_ready, (i % 2 == 0));
         check($sformatf("rr_m1_ready_%0d", i), m1_request_ready, (i % 2 == 1));
         check($sformatf("rr_m0_valid_%0d", i), m0_read_data_valid, (i > 0) && ((i - 1) % 2 == 0));
         check($sformatf("rr_m1_valid_%0d", i), m1_read_data_valid, (i > 0) && ((i - 1) % 2 == 1));
         if (i > 0) check($sformatf("rr_rdata_%0d", i), m0_read_data, 32'hD000 + i);
         tick();
      end
      // last response, issued by m1
      idle();
      s_read_data_valid = 1; s_read_data = 32'hD006;
      #2;
      check("rr_last_m1_valid", m1_read_data_valid, 1);
      check("rr_last_m0_valid", m0_read_data_valid, 0);
      check("rr_last_m1_rdata", m1_read_data, 32'hD006);
      tick();
      idle();

      // ---------------- lock ----------------
      // m1 locked write, m0 idle
      m1_write = 1; m1_lock = 1; m1_address = 32'h1004;
      #2;
      check("lk_a_addr", s_address, 32'h1004);
      check("lk_a_m1_ready", m1_request_ready, 1);
      tick();
      // owner idle, m0 still stalled
      idle();
      m0_read = 1; m0_address = 32'h300;
      #2;
      check("lk_b_m0_ready", m0_request_ready, 0);
      check("lk_b_s_read", s_read, 0);
      check("lk_b_s_write", s_write, 0);
      tick();
      // owner's second write releases the lock
      m1_write = 1; m1_lock = 0; m1_address = 32'h1008;
      m1_byte_en = 4'hC; m1_write_data = 32'hCAFE;
      #2;
      check("lk_c_addr", s_address, 32'h1008);
      check("lk_c_s_write", s_write, 1);
      check("lk_c_byte_en", s_byte_en, 4'hC);
      check("lk_c_wdata", s_write_data, 32'hCAFE);
      check("lk_c_m1_ready", m1_request_ready, 1);
      check("lk_c_m0_ready", m0_request_ready, 0);
      tick();
      m1_write = 0; m1_byte_en = '1; m1_write_data = '0;
      #2;
      check("lk_d_addr", s_address, 32'h300);
      check("lk_d_m0_ready", m0_request_ready, 1);
      tick();
      idle();
      s_read_data_valid = 1; s_read_data = 32'h3333;
      #2;
      check("lk_e_m0_valid", m0_read_data_valid, 1);
      tick();
      idle();

      // ---------------- full ID queue ----------------
      for (int i = 0; i < 4; i++) begin
         m0_read = 1; m0_address = 32'h400 + 4 * i;
         #2;
         check($sformatf("fl_acc_ready_%0d", i), m0_request_ready, 1);
         check($sformatf("fl_acc_s_read_%0d", i), s_read, 1);
         tick();
      end
      m0_address = 32'h410;
      #2;
      check("fl_5th_ready", m0_request_ready, 0);
      check("fl_5th_s_read", s_read, 0);
      tick();
      // writes pass while full
      m1_write = 1; m1_address = 32'h2000;
      #2;
      check("fl_wr_s_write", s_write, 1);
      check("fl_wr_m1_ready", m1_request_ready, 1);
      check("fl_wr_m0_ready", m0_request_ready, 0);
      tick();
      // pop does not unblock the push in the same cycle
      m1_write = 0;
      s_read_data_valid = 1; s_read_data = 32'hA0;
      #2;
      check("fl_pop_m0_valid", m0_read_data_valid, 1);
      check("fl_pop_rdata", m0_read_data, 32'hA0);
      check("fl_pop_m0_ready", m0_request_ready, 0);
      check("fl_pop_s_read", s_read, 0);
      tick();
      s_read_data_valid = 0;
      #2;
      check("fl_next_m0_ready", m0_request_ready, 1);
      check("fl_next_addr", s_address, 32'h410);
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         s_read_data_valid = 1;
         #2;
         check($sformatf("fl_drain_%0d", i), m0_read_data_valid, 1);
         tick();
      end
      idle();

      // ---------------- interleaved IDs m0, m1, m1, m0 ----------------
      m0_read = 1; m0_address = 32'h600;
      #2; check("il_iss_0", m0_request_ready, 1);
      tick(); idle();
      m1_read = 1; m1_address = 32'h604;
      #2; check("il_iss_1", m1_request_ready, 1);
      tick();
      #2; check("il_iss_2", m1_request_ready, 1);
      tick(); idle();
      m0_read = 1; m0_address = 32'h60C;
      #2; check("il_iss_3", m0_request_ready, 1);
      tick(); idle();
      for (int i = 0; i < 4; i++) begin
         s_read_data_valid = 1; s_read_data = 32'hD0 + i;
         #2;
         check($sformatf("il_m0_valid_%0d", i), m0_read_data_valid, (i == 0 || i == 3));
         check($sformatf("il_m1_valid_%0d", i), m1_read_data_valid, (i == 1 || i == 2));
         check($sformatf("il_rdata_%0d", i), m1_read_data, 32'hD0 + i);
         tick();
      end
      idle();

      // ---------------- response with empty queue ----------------
      s_read_data_valid = 1; s_read_data = 32'hEE;
      #2;
      check("er_m0_valid", m0_read_data_valid, 0);
      check("er_m1_valid", m1_read_data_valid, 0);
      check("er_before", resp_err, 0);
      tick();
      idle();
      #2; check("er_set", resp_err, 1);
      tick();
      #2; check("er_held", resp_err, 1);

      // ---------------- reset mid-burst ----------------
      tick();
      m0_read = 1; m0_lock = 1; m0_address = 32'h500;
      #2; check("mr_iss_0", m0_request_ready, 1);
      tick();
      #2; check("mr_iss_1", m0_request_ready, 1);
      tick();
      m0_lock = 0;
      #1;
      rest = 1;
      #1;
      check("mr_rst_resp_err", resp_err, 0);
      check("mr_rst_s_read", s_read, 0);
      check("mr_rst_m0_ready", m0_request_ready, 0);
      check("mr_rst_addr", s_address, 32'h500);
      tick();
      rest = 0;
      idle();
      // queue cleared: a response now is unmatched
      s_read_data_valid = 1;
      #2;
      check("mr_m0_valid", m0_read_data_valid, 0);
      check("mr_m1_valid", m1_read_data_valid, 0);
      tick();
      idle();
      s_request_ready = 0;
      m0_read = 1; m0_address = 32'h100;
      m1_read = 1; m1_address = 32'h200;
      #2;
      check("mr_resp_err", resp_err, 1);
      check("mr_last_grant", s_address, 32'h100);
      tick();
      // lock cleared: m1 alone is granted
      m0_read = 0;
      #2;
      check("mr_unlocked_addr", s_address, 32'h200);
      check("mr_unlocked_read", s_read, 1);
      tick();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
